// File: rtl/cart_verify_pkg.sv
// Shared types and constants for the cartridge header verifier.
// Covers FSM state encoding, read phases and the fixed checksum window.
package cart_verify_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StRead = 3'd1;
  localparam state_t StWait = 3'd2;
  localparam state_t StGap  = 3'd3;
  localparam state_t StDone = 3'd4;

  typedef enum logic {
    PhasePattern,
    PhaseChecksum
  } phase_t;

  localparam logic [15:0] CSUM_START = 16'h0134;
  localparam logic [15:0] CSUM_LAST  = 16'h014C;
  localparam logic [15:0] CSUM_ADDR  = 16'h014D;
  localparam int unsigned CSUM_BYTES = 26;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/header_checksum_acc.sv
// Running header checksum: x <= x - byte - 1 (mod 256) on each enabled byte.
// Clear has priority over enable.
module header_checksum_acc (
  input  logic       clk_6_7,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] x
);

  logic [7:0] x_q;

  always_ff @(posedge clk_6_7) begin
    if (reset || clear) begin
      x_q <= 8'd0;
    end else if (enable) begin
      x_q <= x_q - data - 8'd1;
    end
  end

  assign x = x_q;

endmodule

// File: rtl/cart_header_verifier.sv
// Reads a header pattern off the cart bus, compares it bytewise, optionally
// verifies the header checksum, and retries a bounded number of times.
module cart_header_verifier
  import cart_verify_pkg::*;
#(
  parameter int unsigned PATTERN_LEN    = 13,
  parameter logic [15:0] BASE_ADDR      = 16'h0134,
  parameter int unsigned READ_DELAY     = 7,
  parameter int unsigned MAX_RETRIES    = 2,
  parameter bit          CHECK_CHECKSUM = 1'b1
) (
  input  logic                     clk_6_7,
  input  logic                     reset,
  input  logic                     verification_req,
  input  logic [8*PATTERN_LEN-1:0] pattern,
  input  logic [7:0]               cart_data,
  output logic                     cart_rd,
  output logic [15:0]              cart_addr,
  output logic                     verifying,
  output logic                     verification_complete,
  output logic                     verification_passed,
  output logic                     pattern_ok,
  output logic                     checksum_ok,
  output logic [4:0]               fail_offset,
  output logic [2:0]               retry_count
);

  localparam logic [4:0] PatLastIdx  = 5'(PATTERN_LEN - 1);
  localparam logic [4:0] CsumLastIdx = 5'(CSUM_BYTES - 1);

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [4:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic [4:0]       foff_q, foff_d;
  logic             pok_q, pok_d;
  logic             cok_q, cok_d;
  logic             complete_q, complete_d;
  logic             req_q;

  logic        req_edge;
  logic [15:0] rd_addr;
  logic [7:0]  pat_byte;
  logic [7:0]  acc_x;
  logic        acc_clear, acc_en;
  logic        attempt_end, attempt_pass;

  assign req_edge = verification_req & ~req_q;

  assign rd_addr = (phase_q == PhasePattern) ? BASE_ADDR + {11'd0, idx_q}
                                             : CSUM_START + {11'd0, idx_q};

  always_comb begin
    pat_byte = 8'd0;
    for (int k = 0; k < int'(PATTERN_LEN); k++) begin
      if (idx_q == 5'(k)) pat_byte = pattern[8*k +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    foff_d       = foff_q;
    pok_d        = pok_q;
    cok_d        = cok_q;
    complete_d   = complete_q;
    acc_clear    = 1'b0;
    acc_en       = 1'b0;
    attempt_end  = 1'b0;
    attempt_pass = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        // complete rises one cycle after entering DONE
        if (state_q == StDone) complete_d = 1'b1;
        if (req_edge) begin
          state_d    = StRead;
          phase_d    = PhasePattern;
          idx_d      = 5'd0;
          retry_d    = 3'd0;
          foff_d     = 5'd0;
          pok_d      = 1'b0;
          cok_d      = 1'b0;
          complete_d = 1'b0;
          acc_clear  = 1'b1;
        end
      end
      StRead: begin
        cnt_d   = CNT_W'(READ_DELAY);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (phase_q == PhasePattern) begin
          if (cart_data != pat_byte) begin
            foff_d      = idx_q;
            pok_d       = 1'b0;
            attempt_end = 1'b1;
          end else if (idx_q == PatLastIdx) begin
            pok_d = 1'b1;
            if (CHECK_CHECKSUM) begin
              phase_d   = PhaseChecksum;
              idx_d     = 5'd0;
              state_d   = StRead;
              acc_clear = 1'b1;
            end else begin
              attempt_end  = 1'b1;
              attempt_pass = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = StRead;
          end
        end else begin
          if (idx_q == CsumLastIdx) begin
            cok_d        = (rd_addr == CSUM_ADDR) && (cart_data == acc_x);
            attempt_end  = 1'b1;
            attempt_pass = cok_d;
          end else begin
            acc_en  = (rd_addr <= CSUM_LAST);
            idx_d   = idx_q + 5'd1;
            state_d = StRead;
          end
        end

        if (attempt_end) begin
          if (attempt_pass) begin
            state_d = StDone;
          end else if (retry_q < 3'(MAX_RETRIES)) begin
            retry_d = retry_q + 3'd1;
            state_d = StGap;
          end else begin
            state_d = StDone;
          end
        end
      end
      StGap: begin
        pok_d     = 1'b0;
        cok_d     = 1'b0;
        foff_d    = 5'd0;
        phase_d   = PhasePattern;
        idx_d     = 5'd0;
        state_d   = StRead;
        acc_clear = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_6_7) begin
    if (reset) begin
      state_q    <= StIdle;
      phase_q    <= PhasePattern;
      idx_q      <= 5'd0;
      cnt_q      <= '0;
      retry_q    <= 3'd0;
      foff_q     <= 5'd0;
      pok_q      <= 1'b0;
      cok_q      <= 1'b0;
      complete_q <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      foff_q     <= foff_d;
      pok_q      <= pok_d;
      cok_q      <= cok_d;
      complete_q <= complete_d;
      req_q      <= verification_req;
    end
  end

  header_checksum_acc u_csum (
    .clk_6_7 (clk_6_7),
    .reset   (reset),
    .clear   (acc_clear),
    .enable  (acc_en),
    .data    (cart_data),
    .x       (acc_x)
  );

  // Bus outputs decode straight from state so a reset drops them on the same edge.
  assign verifying             = (state_q == StRead) || (state_q == StWait);
  assign cart_rd               = verifying;
  assign cart_addr             = verifying ? rd_addr : 16'd0;
  assign verification_complete = complete_q;
  assign pattern_ok            = pok_q;
  assign checksum_ok           = cok_q;
  assign verification_passed   = pok_q && (cok_q || !CHECK_CHECKSUM);
  assign fail_offset           = foff_q;
  assign retry_count           = retry_q;

endmodule

// File: tb/tb_cart_header_verifier.sv
// Directed bench: cart memory model, scoreboard of expected results, two DUT configurations.
module tb_cart_header_verifier;

  logic clk_6_7 = 1'b0;
  always #5 clk_6_7 = ~clk_6_7;

  logic         reset = 1'b1;
  logic         req1 = 1'b0, req2 = 1'b0;
  logic [103:0] pat1 = '0;
  logic [31:0]  pat2 = '0;
  logic [7:0]   data1 = 8'd0, data2 = 8'd0;

  logic        rd1, verifying1, complete1, passed1, pok1, cok1;
  logic [15:0] addr1;
  logic [4:0]  foff1;
  logic [2:0]  retry1;
  logic        rd2, verifying2, complete2, passed2, pok2, cok2;
  logic [15:0] addr2;
  logic [4:0]  foff2;
  logic [2:0]  retry2;

  cart_header_verifier dut1 (
    .clk_6_7               (clk_6_7),
    .reset                 (reset),
    .verification_req      (req1),
    .pattern               (pat1),
    .cart_data             (data1),
    .cart_rd               (rd1),
    .cart_addr             (addr1),
    .verifying             (verifying1),
    .verification_complete (complete1),
    .verification_passed   (passed1),
    .pattern_ok            (pok1),
    .checksum_ok           (cok1),
    .fail_offset           (foff1),
    .retry_count           (retry1)
  );

  cart_header_verifier #(
    .PATTERN_LEN    (4),
    .READ_DELAY     (3),
    .CHECK_CHECKSUM (1'b0)
  ) dut2 (
    .clk_6_7               (clk_6_7),
    .reset                 (reset),
    .verification_req      (req2),
    .pattern               (pat2),
    .cart_data             (data2),
    .cart_rd               (rd2),
    .cart_addr             (addr2),
    .verifying             (verifying2),
    .verification_complete (complete2),
    .verification_passed   (passed2),
    .pattern_ok            (pok2),
    .checksum_ok           (cok2),
    .fail_offset           (foff2),
    .retry_count           (retry2)
  );

  logic [7:0]  mem [0:65535];
  logic [15:0] corrupt_addr = 16'd0;
  int          corrupt_base = 0;
  int          corrupt_limit = 0;
  int          reads_seen = 0;
  logic        prev_rd = 1'b0;
  logic [15:0] prev_addr = 16'd0;

  // Count read starts at the watched address; corrupt the first corrupt_limit of them.
  always @(negedge clk_6_7) begin
    if (rd1 && (!prev_rd || addr1 != prev_addr) && addr1 == corrupt_addr) reads_seen++;
    prev_rd   = rd1;
    prev_addr = addr1;
    if (rd1 && addr1 == corrupt_addr && (reads_seen - corrupt_base) <= corrupt_limit)
      data1 = mem[addr1] ^ 8'hFF;
    else
      data1 = mem[addr1];
    data2 = mem[addr2];
  end

  typedef struct {
    string      tag;
    logic       passed;
    logic       pok;
    logic       cok;
    logic [4:0] foff;
    logic [2:0] retry;
    int         lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          lat, gaps, gap_len, low_run, base_reads, hold_bad;
  logic [15:0] first_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic passed, input logic pok, input logic cok,
                      input logic [4:0] foff, input logic [2:0] retry, input int exp_lat);
    exp_t e;
    e.tag = tag; e.passed = passed; e.pok = pok; e.cok = cok;
    e.foff = foff; e.retry = retry; e.lat = exp_lat;
    sb.push_back(e);
  endtask

  // Raise req; lat counts edges with the detecting edge as 1, until complete is seen.
  task automatic run(input bit sel);
    @(posedge clk_6_7); #1;
    if (sel) req2 = 1'b1; else req1 = 1'b1;
    lat = 0; gaps = 0; gap_len = 0; low_run = 0; first_addr = 16'hFFFF;
    while (lat < 5000) begin
      @(posedge clk_6_7); #1;
      lat++;
      if (lat == 1) first_addr = sel ? addr2 : addr1;
      if (sel ? complete2 : complete1) break;
      if (!(sel ? rd2 : rd1)) low_run++;
      else if (low_run > 0) begin
        gaps++; gap_len = low_run; low_run = 0;
      end
    end
    check("complete_seen", 32'(sel ? complete2 : complete1), 32'd1);
  endtask

  task automatic compare(input bit sel);
    exp_t e;
    e = sb.pop_front();
    check({e.tag, "_passed"}, 32'(sel ? passed2 : passed1), 32'(e.passed));
    check({e.tag, "_pattern_ok"}, 32'(sel ? pok2 : pok1), 32'(e.pok));
    check({e.tag, "_checksum_ok"}, 32'(sel ? cok2 : cok1), 32'(e.cok));
    check({e.tag, "_fail_offset"}, 32'(sel ? foff2 : foff1), 32'(e.foff));
    check({e.tag, "_retry_count"}, 32'(sel ? retry2 : retry1), 32'(e.retry));
    if (e.lat > 0) check({e.tag, "_latency"}, 32'(lat), 32'(e.lat));
  endtask

  initial begin
    string      title;
    logic [7:0] x;
    title = "GAMEBOYCAMERA";
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a * 7 + 3);
    for (int i = 0; i < 13; i++) mem[16'h0134 + 16'(i)] = title[i];
    x = 8'd0;
    for (int a = 16'h0134; a <= 16'h014C; a++) x = x - mem[a] - 8'd1;
    mem[16'h014D] = x;
    for (int i = 0; i < 13; i++) pat1[8*i +: 8] = mem[16'h0134 + 16'(i)];
    for (int i = 0; i < 4; i++) pat2[8*i +: 8] = mem[16'h0134 + 16'(i)];

    repeat (3) @(posedge clk_6_7);
    #1;
    check("rst_cart_rd", 32'(rd1), 32'd0);
    check("rst_cart_addr", 32'(addr1), 32'd0);
    check("rst_verifying", 32'(verifying1), 32'd0);
    check("rst_complete", 32'(complete1), 32'd0);
    check("rst_passed", 32'(passed1), 32'd0);
    check("rst_retry", 32'(retry1), 32'd0);
    check("rst_complete2", 32'(complete2), 32'd0);
    reset = 1'b0;

    // Camera header, all correct
    push("camera", 1'b1, 1'b1, 1'b1, 5'd0, 3'd0, 353);
    run(1'b0);
    req1 = 1'b0;
    compare(1'b0);
    check("camera_first_addr", 32'(first_addr), 32'h0134);

    // 0x138 wrong on every attempt
    corrupt_addr = 16'h0138; corrupt_base = reads_seen; corrupt_limit = 99;
    base_reads = reads_seen;
    push("bad138", 1'b0, 1'b0, 1'b0, 5'd4, 3'd2, 0);
    run(1'b0);
    req1 = 1'b0;
    compare(1'b0);
    check("bad138_reads", 32'(reads_seen - base_reads), 32'd3);
    corrupt_limit = 0;

    // Checksum byte off by one
    mem[16'h014D] = mem[16'h014D] + 8'd1;
    push("badcsum", 1'b0, 1'b1, 1'b0, 5'd0, 3'd2, 0);
    run(1'b0);
    req1 = 1'b0;
    compare(1'b0);
    mem[16'h014D] = mem[16'h014D] - 8'd1;

    // 0x136 corrupted on the first attempt only
    corrupt_addr = 16'h0136; corrupt_base = reads_seen; corrupt_limit = 1;
    push("once136", 1'b1, 1'b1, 1'b1, 5'd0, 3'd1, 0);
    run(1'b0);
    req1 = 1'b0;
    compare(1'b0);
    check("once136_gaps", 32'(gaps), 32'd1);
    check("once136_gap_len", 32'(gap_len), 32'd1);
    corrupt_limit = 0;

    // Reset during WAIT of byte 5, then restart
    @(posedge clk_6_7); #1;
    req1 = 1'b1;
    lat = 0;
    while (lat < 1000) begin
      @(posedge clk_6_7); #1;
      lat++;
      if (rd1 && addr1 == 16'h0139) break;
    end
    check("byte5_reached", 32'(addr1), 32'h0139);
    repeat (3) @(posedge clk_6_7);
    #1;
    reset = 1'b1;
    req1  = 1'b0;
    @(posedge clk_6_7); #1;
    check("midrst_cart_rd", 32'(rd1), 32'd0);
    check("midrst_cart_addr", 32'(addr1), 32'd0);
    check("midrst_verifying", 32'(verifying1), 32'd0);
    reset = 1'b0;
    push("restart", 1'b1, 1'b1, 1'b1, 5'd0, 3'd0, 353);
    run(1'b0);
    req1 = 1'b0;
    compare(1'b0);
    check("restart_first_addr", 32'(first_addr), 32'h0134);

    // Short pattern, no checksum; req held high in DONE must not retrigger
    push("short", 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 22);
    run(1'b1);
    hold_bad = 0;
    repeat (20) begin
      @(posedge clk_6_7); #1;
      if (verifying2 || !complete2) hold_bad++;
    end
    req2 = 1'b0;
    compare(1'b1);
    check("short_hold_no_retrigger", 32'(hold_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cart_header_verifier.md
# cart_header_verifier

Parametrised cartridge header verifier for the Game Boy cart bus. On request it reads a configurable byte pattern starting at a configurable header address and compares it byte-for-byte. It optionally computes the standard header checksum over 0x134–0x14C and compares it against the byte at 0x14D. Bounded retries tolerate transient bus errors. It sits between the cart bus read port and top-level boot/enable logic, and reports pass/fail plus diagnostics.

## Interface
Parameters:
- PATTERN_LEN, 13 — bytes compared; range 1–32
- BASE_ADDR, 16'h0134 — address of pattern byte 0
- READ_DELAY, 7 — wait cycles after address drive before sampling; range 1–15
- MAX_RETRIES, 2 — extra attempts after a failed attempt; range 0–7
- CHECK_CHECKSUM, 1 — 1 enables the header checksum phase

Ports:
- clk_6_7  in  1 — sole clock; all logic on rising edge
- reset  in  1 — synchronous, active-high
- verification_req  in  1 — rising edge starts verification (from IDLE or DONE)
- pattern  in  8*PATTERN_LEN — expected bytes; byte i at [8i+7:8i]; must be stable while verifying
- cart_data  in  8 — cart read data
- cart_rd  out  1 — read strobe
- cart_addr  out  16 — read address
- verifying  out  1 — high in READ/WAIT states
- verification_complete  out  1 — sticky result-valid
- verification_passed  out  1 — pattern_ok && (checksum_ok || !CHECK_CHECKSUM)
- pattern_ok  out  1 — last attempt matched all pattern bytes
- checksum_ok  out  1 — last attempt's checksum matched; 0 when CHECK_CHECKSUM=0
- fail_offset  out  5 — index of the first mismatching pattern byte; 0 if none
- retry_count  out  3 — retries consumed

## Operation
- States: IDLE, READ, WAIT, GAP, DONE.
- Phase P (pattern), index i = 0..PATTERN_LEN-1; address = BASE_ADDR + i.
- Phase C (checksum), index j = 0..25; address = 16'h0134 + j.
- Accumulator x: 8-bit, starts at 0; x <= x - byte - 1 (mod 256) for j ≤ 24. The byte read at j = 25 (0x14D) is compared against x.
- IDLE: outputs cleared. Rising edge of verification_req → READ, phase P, i = 0, retry_count = 0.
- READ (1 cycle): drive cart_addr, cart_rd = 1, load delay counter with READ_DELAY → WAIT.
- WAIT: decrement counter; when it reaches 0, sample cart_data on that edge.
  - Phase P mismatch: capture fail_offset = i, pattern_ok = 0; end the attempt.
  - Phase P match, last byte: set pattern_ok = 1; go to phase C, or to DONE if CHECK_CHECKSUM = 0.
  - Phase C, j = 25: checksum_ok = (byte == x); end the attempt.
  - Otherwise: increment index → READ.
- End of attempt:
  - Passed → DONE.
  - Failed and retry_count < MAX_RETRIES → retry_count++, GAP.
  - Failed otherwise → DONE.
- GAP (1 cycle): cart_rd = 0, cart_addr = 0, clear pattern_ok, checksum_ok and fail_offset; restart phase P at i = 0.
- DONE: cart_rd = 0, verification_complete = 1, results held. A new rising edge of verification_req restarts as from IDLE. A held-high req does not retrigger.
- The req edge detector uses a registered copy of verification_req, cleared by reset.

## Timing
- Reset: all outputs 0, state IDLE, edge register 0. Reset mid-read drops cart_rd on the same edge.
- Each byte takes exactly READ_DELAY + 2 cycles; 9 at the default.
- cart_addr and cart_rd stay stable from READ through the sampling edge.
- Latency from the req-edge-detect edge to the first verification_complete = 1 is 1 + (READ_DELAY+2)·(bytes read) + 1 cycles.
  - Defaults, all pass: bytes = 13 + 26 = 39 → 353 cycles.
- Early pattern mismatch shortens an attempt. Each retry adds 1 GAP cycle.
- A req rising edge during READ/WAIT/GAP is ignored.
- Offset arithmetic: BASE_ADDR + i in 16 bits, wraps at 16'hFFFF.

## Structure
- Package cart_verify_pkg holds:
  - state enum
  - CSUM_START = 16'h0134, CSUM_LAST = 16'h014C, CSUM_ADDR = 16'h014D, CSUM_BYTES = 26
  - delay counter width (4)
- Sub-module header_checksum_acc (clear, enable, byte in, 8-bit x out) holds the accumulator.

## Test plan
- Camera header "GAMEBOYCAMERA" at 0x134 with correct checksum byte at 0x14D, defaults:
  - complete at cycle 353
  - passed = 1, pattern_ok = 1, checksum_ok = 1, retry_count = 0
- Byte at 0x138 wrong on every attempt:
  - fail_offset = 4, pattern_ok = 0, passed = 0, retry_count = 2
  - exactly 3 reads of 0x138
- Pattern correct, 0x14D corrupted by +1:
  - pattern_ok = 1, checksum_ok = 0, passed = 0
  - retry_count = 2
- 0x136 corrupted on the first attempt only:
  - passed = 1, retry_count = 1
  - cart_rd low for exactly one cycle between attempts
- reset asserted mid-WAIT of byte 5:
  - next edge: cart_rd = 0, cart_addr = 0, verifying = 0
  - a new req edge restarts at 0x134
- CHECK_CHECKSUM = 0, PATTERN_LEN = 4, READ_DELAY = 3:
  - complete after 1 + 5·4 + 1 = 22 cycles, checksum_ok = 0, passed = 1
  - holding req high in DONE does not retrigger
